// File: rtl/id_stage.sv
// id_stage: instruction decode with load-use / branch-source stall counter and jump/branch resolution.
// Rev 1.0. Macro DELAY_SLOT_EN: defined keeps IFkill low (delay slot), undefined kills fetch on a transfer.
`default_nettype none

module id_stage (
  input  logic         clk,
  input  logic         IDrst,
  input  logic [95:0]  IFreg,
  input  logic         IDhold,
  output logic [4:0]   rsAddr,
  output logic [4:0]   rtAddr,
  input  logic [31:0]  rsData,
  input  logic [31:0]  rtData,
  input  logic         exMemRead,
  input  logic         exRegWrite,
  input  logic [4:0]   exDest,
  output logic         pcHold,
  output logic         IFhold,
  output logic         IFkill,
  output logic         jflag,
  output logic         jrflag,
  output logic         brflag,
  output logic [31:0]  jPC,
  output logic [31:0]  jrPC,
  output logic [31:0]  brPC,
  output logic [145:0] IDreg
);

  localparam logic [1:0] c_RUN      = 2'd0;
  localparam logic [1:0] c_REL      = 2'd1;
  localparam logic [1:0] c_LONG     = 2'd2;
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_BNE   = 6'h05;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_FN_JR    = 6'h08;
`ifdef DELAY_SLOT_EN
  localparam logic       c_KILL_EN  = 1'b0;
`else
  localparam logic       c_KILL_EN  = 1'b1;
`endif

  logic [1:0]   r_cnt;
  logic [1:0]   w_cnt_nxt;
  logic [1:0]   w_haz_cnt;
  logic [145:0] r_idreg;
  logic [145:0] w_decoded;
  logic         w_decode;
  logic         w_bubble;

  logic [31:0] w_pc4;
  logic [31:0] w_instr;
  logic [31:0] w_pc8;
  logic [5:0]  w_op;
  logic [5:0]  w_funct;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_imm32;

  logic w_is_r, w_is_jr, w_is_imm, w_is_lw, w_is_sw, w_is_beq, w_is_bne, w_is_j, w_is_jal;
  logic w_zext;
  logic w_alu_src, w_mem_to_reg, w_mem_write, w_mem_read, w_we_raw, w_reg_write, w_link;
  logic [5:0] w_alu_op;
  logic [4:0] w_dest;
  logic w_reads_rs, w_reads_rt, w_hit_rs, w_hit_rt, w_load_use, w_br_src;
  logic w_taken;

  assign w_pc4   = IFreg[95:64];
  assign w_instr = IFreg[63:32];
  assign w_pc8   = IFreg[31:0];
  assign w_op    = w_instr[31:26];
  assign w_rs    = w_instr[25:21];
  assign w_rt    = w_instr[20:16];
  assign w_rd    = w_instr[15:11];
  assign w_funct = w_instr[5:0];

  assign rsAddr = w_rs;
  assign rtAddr = w_rt;

  assign w_is_r   = (w_op == c_OP_RTYPE);
  assign w_is_jr  = w_is_r && (w_funct == c_FN_JR);
  assign w_is_imm = (w_op[5:3] == 3'b001);
  assign w_is_lw  = (w_op == c_OP_LW);
  assign w_is_sw  = (w_op == c_OP_SW);
  assign w_is_beq = (w_op == c_OP_BEQ);
  assign w_is_bne = (w_op == c_OP_BNE);
  assign w_is_j   = (w_op == c_OP_J);
  assign w_is_jal = (w_op == c_OP_JAL);

  // andi/ori/xori take a zero-extended immediate
  assign w_zext  = (w_op == 6'h0C) || (w_op == 6'h0D) || (w_op == 6'h0E);
  assign w_imm32 = w_zext ? {16'h0000, w_instr[15:0]} : {{16{w_instr[15]}}, w_instr[15:0]};

  always_comb begin
    w_alu_src    = 1'b0;
    w_mem_to_reg = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_we_raw     = 1'b0;
    w_link       = 1'b0;
    w_alu_op     = 6'd0;
    w_dest       = 5'd0;
    if (w_is_r) begin
      w_alu_op = w_funct;
      w_dest   = w_rd;
      w_we_raw = !w_is_jr;
    end else if (w_is_imm) begin
      w_alu_src = 1'b1;
      w_alu_op  = w_op;
      w_dest    = w_rt;
      w_we_raw  = 1'b1;
    end else if (w_is_lw) begin
      w_alu_src    = 1'b1;
      w_mem_to_reg = 1'b1;
      w_mem_read   = 1'b1;
      w_dest       = w_rt;
      w_we_raw     = 1'b1;
    end else if (w_is_sw) begin
      w_alu_src   = 1'b1;
      w_mem_write = 1'b1;
    end else if (w_is_jal) begin
      w_link   = 1'b1;
      w_dest   = 5'd31;
      w_we_raw = 1'b1;
    end
  end

  assign w_reg_write = w_we_raw && (w_dest != 5'd0);
  assign w_decoded   = {w_pc8, rsData, rtData, w_imm32, w_dest, 1'b1, w_link, w_alu_src,
                        w_mem_to_reg, w_mem_write, w_mem_read, w_reg_write, w_alu_op};

  // j/jal carry target bits in the rs field, so they never read rs
  assign w_reads_rs = !(w_is_j || w_is_jal);
  assign w_reads_rt = (w_is_r && !w_is_jr) || w_is_sw || w_is_beq || w_is_bne;
  assign w_hit_rs   = (exDest != 5'd0) && (exDest == w_rs) && w_reads_rs;
  assign w_hit_rt   = (exDest != 5'd0) && (exDest == w_rt) && w_reads_rt;
  assign w_load_use = exMemRead && (w_hit_rs || w_hit_rt);
  assign w_br_src   = ((w_is_beq || w_is_bne) && (w_hit_rs || w_hit_rt)) || (w_is_jr && w_hit_rs);

  always_comb begin
    w_haz_cnt = c_RUN;
    if (w_br_src && exMemRead)       w_haz_cnt = c_LONG;
    else if (w_br_src && exRegWrite) w_haz_cnt = c_REL;
    else if (w_load_use)             w_haz_cnt = c_REL;
  end

  // Detect cycle is the first bubble; the cnt==1 cycle re-decodes without re-checking hazards.
  always_comb begin
    w_cnt_nxt = r_cnt;
    w_decode  = 1'b0;
    w_bubble  = 1'b0;
    if (!IDhold) begin
      if (r_cnt == c_RUN) begin
        if (w_haz_cnt != c_RUN) begin
          w_cnt_nxt = w_haz_cnt;
          w_bubble  = 1'b1;
        end else begin
          w_decode = 1'b1;
        end
      end else begin
        w_cnt_nxt = r_cnt - 2'd1;
        if (r_cnt == c_REL) w_decode = 1'b1;
        else                w_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge IDrst) begin
    if (IDrst) r_cnt <= c_RUN;
    else       r_cnt <= w_cnt_nxt;
  end

  always_ff @(posedge clk or posedge IDrst) begin
    if (IDrst)         r_idreg <= '0;
    else if (w_decode) r_idreg <= w_decoded;
    else if (w_bubble) r_idreg <= '0;
  end

  assign IDreg   = r_idreg;
  assign w_taken = (w_is_beq && (rsData == rtData)) || (w_is_bne && (rsData != rtData));
  assign jPC     = {w_pc4[31:28], w_instr[25:0], 2'b00};
  assign jrPC    = rsData;
  assign brPC    = w_pc4 + {w_imm32[29:0], 2'b00};

  always_comb begin
    pcHold = !IDrst && !w_decode;
    IFhold = !IDrst && !w_decode;
    jflag  = !IDrst && w_decode && (w_is_j || w_is_jal);
    jrflag = !IDrst && w_decode && w_is_jr;
    brflag = !IDrst && w_decode && w_taken;
    IFkill = c_KILL_EN && (jflag || jrflag || brflag);
  end

endmodule

`default_nettype wire

// File: tb/tb_id_stage.sv
// tb_id_stage: randomized scoreboard bench for id_stage against a transaction-level reference model.
`default_nettype none

module tb_id_stage;

  logic         clk = 1'b0;
  logic         IDrst;
  logic [95:0]  IFreg;
  logic         IDhold;
  logic [4:0]   rsAddr, rtAddr;
  logic [31:0]  rsData, rtData;
  logic         exMemRead, exRegWrite;
  logic [4:0]   exDest;
  logic         pcHold, IFhold, IFkill, jflag, jrflag, brflag;
  logic [31:0]  jPC, jrPC, brPC;
  logic [145:0] IDreg;

  id_stage dut (
    .clk(clk), .IDrst(IDrst), .IFreg(IFreg), .IDhold(IDhold),
    .rsAddr(rsAddr), .rtAddr(rtAddr), .rsData(rsData), .rtData(rtData),
    .exMemRead(exMemRead), .exRegWrite(exRegWrite), .exDest(exDest),
    .pcHold(pcHold), .IFhold(IFhold), .IFkill(IFkill),
    .jflag(jflag), .jrflag(jrflag), .brflag(brflag),
    .jPC(jPC), .jrPC(jrPC), .brPC(brPC), .IDreg(IDreg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [5:0]   ctl;    // {pcHold, IFhold, IFkill, jflag, jrflag, brflag}
    logic [9:0]   addrs;
    logic [1:0]   tsel;   // 0 none, 1 jPC, 2 jrPC, 3 brPC
    logic [31:0]  tgt;
    logic [145:0] idreg;
  } exp_t;

  exp_t         sb[$];
  int           n_cmp  = 0;
  int           n_fail = 0;
  logic [145:0] prev   = '0;

  task automatic chk(input string name, input logic [145:0] act, input logic [145:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [95:0] mkif(input logic [31:0] pc, input logic [31:0] ins);
    return {pc + 32'd4, ins, pc + 32'd8};
  endfunction

  // Reference decode, straight from the opcode table
  function automatic logic [145:0] ref_decode(input logic [95:0] ifr, input logic [31:0] rsd, input logic [31:0] rtd);
    logic [31:0] ins, imm;
    logic [5:0]  op, fn, aluop;
    logic [4:0]  dest;
    logic        link, asrc, m2r, mw, mr, we;
    ins = ifr[63:32]; op = ins[31:26]; fn = ins[5:0];
    {link, asrc, m2r, mw, mr, we} = 6'b0; aluop = 6'd0; dest = 5'd0;
    if (op >= 6'h0C && op <= 6'h0E) imm = {16'h0, ins[15:0]};
    else                            imm = {{16{ins[15]}}, ins[15:0]};
    case (op) inside
      6'h00:          begin aluop = fn; dest = ins[15:11]; we = (fn != 6'h08); end
      [6'h08:6'h0F]:  begin asrc = 1; aluop = op; dest = ins[20:16]; we = 1; end
      6'h23:          begin asrc = 1; m2r = 1; mr = 1; dest = ins[20:16]; we = 1; end
      6'h2B:          begin asrc = 1; mw = 1; end
      6'h03:          begin link = 1; dest = 5'd31; we = 1; end
      default:        ;
    endcase
    if (dest == 5'd0) we = 0;
    return {ifr[31:0], rsd, rtd, imm, dest, 1'b1, link, asrc, m2r, mw, mr, we, aluop};
  endfunction

  // Number of bubbles the instruction must suffer given what sits in EX
  function automatic int ref_bubbles(input logic [31:0] ins, input logic mr, input logic rw, input logic [4:0] d);
    logic [5:0] op, fn;
    bit rd_rs, rd_rt, hit_rs, hit_rt, brsrc;
    op = ins[31:26]; fn = ins[5:0];
    rd_rs  = !(op == 6'h02 || op == 6'h03);
    rd_rt  = (op == 6'h00 && fn != 6'h08) || op == 6'h2B || op == 6'h04 || op == 6'h05;
    hit_rs = (d != 0) && (d == ins[25:21]) && rd_rs;
    hit_rt = (d != 0) && (d == ins[20:16]) && rd_rt;
    brsrc  = ((op == 6'h04 || op == 6'h05) && (hit_rs || hit_rt)) || (op == 6'h00 && fn == 6'h08 && hit_rs);
    if (brsrc && mr) return 2;
    if (brsrc && rw) return 1;
    if (mr && (hit_rs || hit_rt)) return 1;
    return 0;
  endfunction

  function automatic exp_t ref_final(input logic [95:0] ifr, input logic [31:0] rsd, input logic [31:0] rtd);
    exp_t e;
    logic [31:0] ins, pc4, sext;
    logic [5:0]  op;
    bit j, jr, br, kill;
    ins = ifr[63:32]; pc4 = ifr[95:64]; op = ins[31:26];
    sext = {{16{ins[15]}}, ins[15:0]};
    j  = (op == 6'h02 || op == 6'h03);
    jr = (op == 6'h00 && ins[5:0] == 6'h08);
    br = (op == 6'h04 && rsd == rtd) || (op == 6'h05 && rsd != rtd);
`ifdef DELAY_SLOT_EN
    kill = 0;
`else
    kill = j || jr || br;
`endif
    e = '0;
    e.ctl   = {2'b00, kill, j, jr, br};
    e.addrs = {ins[25:21], ins[20:16]};
    e.idreg = ref_decode(ifr, rsd, rtd);
    if (j)       begin e.tsel = 2'd1; e.tgt = {pc4[31:28], 28'(ins[25:0]) * 28'd4}; end
    else if (jr) begin e.tsel = 2'd2; e.tgt = rsd; end
    else if (br) begin e.tsel = 2'd3; e.tgt = pc4 + sext * 32'd4; end
    return e;
  endfunction

  task automatic drive(input logic [95:0] ifr, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic hold, input logic mr, input logic rw, input logic [4:0] d, input exp_t e);
    @(negedge clk);
    IFreg = ifr; rsData = rsd; rtData = rtd; IDhold = hold;
    exMemRead = mr; exRegWrite = rw; exDest = d;
    sb.push_back(e);
  endtask

  // One instruction from first presentation to its decode into IDreg
  task automatic issue(input logic [95:0] ifr, input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic mr, input logic rw, input logic [4:0] d, input int pre_hold, input bit noisy);
    exp_t hb, fin;
    int   n;
    logic nmr, nrw;
    logic [4:0] nd;
    n   = ref_bubbles(ifr[63:32], mr, rw, d);
    fin = ref_final(ifr, rsd, rtd);
    hb  = '0; hb.ctl = 6'b110000; hb.addrs = fin.addrs;
    for (int i = 0; i < pre_hold; i++) begin
      hb.idreg = prev;
      drive(ifr, rsd, rtd, 1'b1, mr, rw, d, hb);
    end
    for (int b = 0; b <= n; b++) begin
      nmr = mr; nrw = rw; nd = d;
      if (b > 0 && noisy) begin
        nmr = 1'($urandom_range(0, 1)); nrw = 1'($urandom_range(0, 1)); nd = 5'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0) begin
          hb.idreg = prev;
          drive(ifr, rsd, rtd, 1'b1, nmr, nrw, nd, hb);
        end
      end
      if (b < n) begin
        hb.idreg = '0;
        drive(ifr, rsd, rtd, 1'b0, nmr, nrw, nd, hb);
        prev = '0;
      end else begin
        drive(ifr, rsd, rtd, 1'b0, nmr, nrw, nd, fin);
        prev = fin.idreg;
      end
    end
  endtask

  task automatic reset_pulse();
    @(posedge clk); #2;
    IDrst = 1'b1; #1;
    chk("rst_idreg", IDreg, '0);
    chk("rst_ctl", {pcHold, IFhold, IFkill, jflag, jrflag, brflag}, '0);
    #1 IDrst = 1'b0;
    prev = '0;
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0] rs, rt, rd;
    logic [5:0] fn;
    int k;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
    fn = 6'($urandom);
    k  = $urandom_range(0, 12);
    case (k)
      0, 1:  return {6'h00, rs, rt, rd, 5'($urandom), (k == 0) ? 6'h20 : fn};
      2:     return {6'($urandom_range(8, 15)), rs, rt, 16'($urandom)};
      3:     return {6'h23, rs, rt, 16'($urandom)};
      4:     return {6'h2B, rs, rt, 16'($urandom)};
      5, 6:  return {6'($urandom_range(4, 5)), rs, rt, 16'($urandom)};
      7, 8:  return {6'($urandom_range(2, 3)), 26'($urandom)};
      9:     return {6'h00, rs, 15'd0, 6'h08};
      10:    return 32'd0;
      11:    return {6'($urandom_range(16, 63)), rs, rt, 16'($urandom)};
      default: return {6'($urandom_range(12, 14)), rs, rt, 16'($urandom)};
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk); #3;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("ctl", {pcHold, IFhold, IFkill, jflag, jrflag, brflag}, e.ctl);
        chk("addr", {rsAddr, rtAddr}, e.addrs);
        if (e.tsel == 2'd1) chk("jPC", jPC, e.tgt);
        if (e.tsel == 2'd2) chk("jrPC", jrPC, e.tgt);
        if (e.tsel == 2'd3) chk("brPC", brPC, e.tgt);
        @(posedge clk); #1;
        chk("idreg", IDreg, e.idreg);
      end
    end
  end

  initial begin : stim
    logic [31:0] ins, rsd, rtd;
    IDrst = 1'b1; IDhold = 1'b1; IFreg = mkif(32'h100, {6'h03, 26'h40});
    rsData = 0; rtData = 0; exMemRead = 1; exRegWrite = 1; exDest = 5'd0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_idreg", IDreg, '0);
    chk("rst_ctl", {pcHold, IFhold, IFkill, jflag, jrflag, brflag}, '0);
    IDrst = 1'b0;

    // killed slot, then plain add
    issue(96'd0, 32'h11, 32'h22, 1'b0, 1'b0, 5'd0, 0, 0);
    issue(mkif(32'h0040_0000, {6'h00, 5'd1, 5'd2, 5'd8, 5'd0, 6'h20}), 32'hA, 32'hB, 1'b0, 1'b1, 5'd3, 0, 0);
    // lw r5 in EX, add r6,r5,r7
    issue(mkif(32'h0040_0004, {6'h00, 5'd5, 5'd7, 5'd6, 5'd0, 6'h20}), 32'h5, 32'h7, 1'b1, 1'b0, 5'd5, 0, 0);
    // beq r5,r5,-1 behind a load into r5
    issue(mkif(32'h0040_0010, {6'h04, 5'd5, 5'd5, 16'hFFFF}), 32'h9, 32'h9, 1'b1, 1'b1, 5'd5, 0, 0);
    // jal 0x40 at 0x10000000
    issue(mkif(32'h1000_0000, {6'h03, 26'h40}), 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 0, 0);
    // taken bne, no hazard
    issue(mkif(32'h0040_0100, {6'h05, 5'd1, 5'd2, 16'h0010}), 32'h1, 32'h2, 1'b0, 1'b0, 5'd0, 0, 0);
    // load-use held for 3 cycles
    issue(mkif(32'h0040_0200, {6'h00, 5'd5, 5'd7, 5'd6, 5'd0, 6'h20}), 32'h5, 32'h7, 1'b1, 1'b0, 5'd5, 3, 0);
    // jr r9 behind an ALU write to r9; ori zero-extension
    issue(mkif(32'h0040_0300, {6'h00, 5'd9, 15'd0, 6'h08}), 32'h0040_1234, 32'h0, 1'b0, 1'b1, 5'd9, 0, 0);
    issue(mkif(32'h0040_0304, {6'h0D, 5'd1, 5'd4, 16'h8001}), 32'h1, 32'h0, 1'b0, 1'b0, 5'd0, 0, 0);

    // reset with a decoded instruction in IDreg, then mid-stall reset
    reset_pulse();
    ins = {6'h04, 5'd5, 5'd6, 16'h0003};
    begin
      exp_t hb;
      hb = '0; hb.ctl = 6'b110000; hb.addrs = {5'd5, 5'd6};
      drive(mkif(32'h0050_0000, ins), 32'h4, 32'h4, 1'b0, 1'b1, 1'b0, 5'd6, hb);
    end
    reset_pulse();
    issue(mkif(32'h0050_0000, ins), 32'h4, 32'h4, 1'b0, 1'b0, 5'd0, 0, 0);

    for (int t = 0; t < 300; t++) begin
      ins = rnd_instr();
      rsd = $urandom;
      rtd = ($urandom_range(0, 1) == 1) ? rsd : 32'($urandom);
      issue(mkif(32'($urandom) & 32'hFFFF_FFFC, ins), rsd, rtd,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 5) == 0) ? 1 : 0, 1);
    end

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk); #2;
    if (sb.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain: %0d expected responses left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; IDrst in 1, asynchronous active-high reset.
REQ-002 SHALL have: IFreg in 96 ([95:64] PC+4, [63:32] instr, [31:0] PC+8); IDhold in 1, external freeze.
REQ-003 SHALL have: rsAddr, rtAddr out 5 each (instr[25:21], instr[20:16]); rsData, rtData in 32 (register file read data).
REQ-004 SHALL have: exMemRead in 1, exRegWrite in 1, exDest in 5 (instruction currently in EX).
REQ-005 SHALL have: pcHold, IFhold, IFkill out 1; jflag, jrflag, brflag out 1; jPC, jrPC, brPC out 32.
REQ-006 SHALL have IDreg out 146: [145:114] PC+8, [113:82] rsData, [81:50] rtData, [49:18] imm32, [17:13] dest, [12:0] ctrl = {valid, link, aluSrc, memToReg, memWrite, memRead, regWrite, aluOp[5:0]}.

Function
REQ-007 SHALL decode opcode instr[31:26]: 0x00 R-type (aluOp=funct, dest=rd); 0x08-0x0F imm ALU (aluSrc, dest=rt); 0x23 lw; 0x2B sw; 0x04 beq; 0x05 bne; 0x02 j; 0x03 jal (link, dest=31); other opcodes: ctrl=0 except valid.
REQ-008 SHALL sign-extend instr[15:0] to imm32; opcodes 0x0C-0x0E SHALL zero-extend instead.
REQ-009 SHALL treat R-type funct 0x08 as jr: no regWrite, jrflag source.
REQ-010 SHALL contain stall counter cnt[1:0]; state RUN when cnt=0, STALL otherwise.
REQ-011 In RUN, load-use hazard = exMemRead & exDest!=0 & (exDest==rs | (exDest==rt & instr reads rt)); SHALL load cnt=1.
REQ-012 In RUN, branch/jr source matching exDest!=0 with exMemRead SHALL load cnt=2; with exRegWrite only SHALL load cnt=1.
REQ-013 While cnt!=0 or hazard detected: pcHold=IFhold=1, IDreg SHALL load bubble (all 146 bits 0), all flags 0; cnt decrements each non-held cycle.
REQ-014 Hazards SHALL NOT be re-evaluated while cnt!=0; on cnt reaching 0 the held instruction re-decodes.
REQ-015 In RUN without hazard: IDreg SHALL load decoded fields next edge, valid=1; 1-cycle latency.
REQ-016 j/jal: jflag=1, jPC={PC+4[31:28], instr[25:0], 2'b00}; jr: jrflag=1, jrPC=rsData.
REQ-017 beq taken when rsData==rtData, bne when unequal: brflag=1, brPC=PC+4+(imm32<<2), 32-bit wrap, carry discarded.
REQ-018 Flags SHALL be combinational, at most one asserted, zero during stall, IDhold, or reset.
REQ-019 IDhold=1: IDreg retains, cnt frozen, pcHold=IFhold=1; IDhold overrides hazard load and flags.
REQ-020 Killed input (IFreg=0, instr=0) SHALL decode as valid nop with regWrite to r0 suppressed (regWrite=0 when dest=0).

Reset
REQ-021 IDrst=1 SHALL immediately clear IDreg to 0 and cnt to 0 regardless of clk.
REQ-022 During IDrst: pcHold=IFhold=IFkill=0, all flags 0; first edge after release decodes IFreg normally.
REQ-023 Reset mid-stall SHALL abandon the stall; no bubble count survives.

Configuration
REQ-024 Macro DELAY_SLOT_EN SHALL select control-transfer semantics.
REQ-025 Defined: IFkill SHALL stay 0; instruction after a transfer executes (delay slot); link value PC+8.
REQ-026 Undefined: IFkill=1 in any cycle jflag|jrflag|brflag=1, else 0; link value still PC+8.

Verification
REQ-027 Reset: IDrst pulse mid-cycle -> IDreg=0 and cnt=0 before next edge, flags 0.
REQ-028 lw r5 in EX (exMemRead=1, exDest=5), ID add r6,r5,r7 -> one bubble, pcHold=IFhold=1 one cycle, then add in IDreg valid=1.
REQ-029 beq r5,r5 with exMemRead=1, exDest=5 -> two bubbles, then brflag=1, brPC=PC+4+imm*4; imm=0xFFFF gives PC.
REQ-030 jal target 0x0000040 at PC 0x10000000 -> jflag=1, jPC=0x10000100, IDreg dest=31, link=1, PC+8 field=0x10000008.
REQ-031 Taken bne with/without DELAY_SLOT_EN -> IFkill 0 / 1 in same cycle as brflag.
REQ-032 IDhold=1 during load-use detect for 3 cycles -> IDreg unchanged, no bubble; on release exactly one bubble then instruction.
